// File: rtl/div_unit.sv
// div_unit -- iterative 32-bit integer divider (DIV / DIVU / REM / REMU).
//
// One restoring iteration per clock on operand magnitudes, with the sign
// fixed up when the result is registered. A zero divisor and signed overflow
// skip the iteration and produce their result on the cycle after accept.
//
// Ports
//   i_clk      clock, rising edge
//   i_reset    synchronous active-high reset
//   i_start    request, accepted only while o_ready=1
//   i_op       00 DIV, 01 DIVU, 10 REM, 11 REMU
//   i_a, i_b   dividend, divisor
//   i_rd       destination tag, echoed on o_rd
//   i_flush    abort the in-flight operation
//   o_ready    high only in IDLE
//   o_valid    one-cycle result strobe
//   o_result   quotient or remainder, held until the next result
//   o_rd       tag of the operation that produced o_result
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for i_start; o_ready=1
// S_CALC | 32 restoring iterations, counter runs 31 down to 0
// S_DONE | o_valid=1 for one cycle, then back to IDLE

module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic [4:0]      i_rd,
    input  logic            i_flush,
    output logic            o_ready,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result,
    output logic [4:0]      o_rd
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};

    state_t          state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic            rem_sel_q, rem_sel_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] bmag_q, bmag_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [4:0]      rd_out_q, rd_out_d;

    // accept-time decode
    logic            op_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            overflow;
    logic [XLEN-1:0] special_result;

    // iteration datapath
    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   diff;
    logic            borrow;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] quo_next;
    logic [XLEN-1:0] q_final;
    logic [XLEN-1:0] r_final;
    logic [XLEN-1:0] calc_result;

    always_comb begin
        op_signed = ~i_op[0];
        a_neg     = op_signed & i_a[XLEN-1];
        b_neg     = op_signed & i_b[XLEN-1];
        // two's-complement negate of MIN_NEG yields 2^31 as an unsigned value
        a_mag     = a_neg ? -i_a : i_a;
        b_mag     = b_neg ? -i_b : i_b;
        div_zero  = (i_b == '0);
        overflow  = op_signed && (i_a == MIN_NEG) && (i_b == ALL_ONE);
        if (div_zero) begin
            special_result = i_op[1] ? i_a : ALL_ONE;
        end else begin
            special_result = i_op[1] ? '0 : MIN_NEG;
        end
    end

    always_comb begin
        rem_shift = {rem_q, quo_q[XLEN-1]};
        // rem < |b| keeps rem_shift < 2|b|, so bit XLEN of the difference is
        // set exactly when the subtract borrows
        diff      = rem_shift - {1'b0, bmag_q};
        borrow    = diff[XLEN];
        rem_next  = borrow ? rem_shift[XLEN-1:0] : diff[XLEN-1:0];
        quo_next  = {quo_q[XLEN-2:0], ~borrow};
        q_final   = qneg_q ? -quo_next : quo_next;
        r_final   = rneg_q ? -rem_next : rem_next;
        calc_result = rem_sel_q ? r_final : q_final;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_sel_d = rem_sel_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        rd_d      = rd_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        bmag_d    = bmag_q;
        result_d  = result_q;
        rd_out_d  = rd_out_q;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    rem_sel_d = i_op[1];
                    rd_d      = i_rd;
                    if (div_zero || overflow) begin
                        result_d = special_result;
                        rd_out_d = i_rd;
                        state_d  = S_DONE;
                    end else begin
                        rem_d   = '0;
                        quo_d   = a_mag;
                        bmag_d  = b_mag;
                        qneg_d  = a_neg ^ b_neg;
                        rneg_d  = a_neg;
                        cnt_d   = 5'd31;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                rem_d = rem_next;
                quo_d = quo_next;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    result_d = calc_result;
                    rd_out_d = rd_q;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // flush wins over everything above, including an accept, and leaves
        // the visible result untouched
        if (i_flush) begin
            state_d   = S_IDLE;
            cnt_d     = cnt_q;
            rem_sel_d = rem_sel_q;
            qneg_d    = qneg_q;
            rneg_d    = rneg_q;
            rd_d      = rd_q;
            rem_d     = rem_q;
            quo_d     = quo_q;
            bmag_d    = bmag_q;
            result_d  = result_q;
            rd_out_d  = rd_out_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_sel_q <= 1'b0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            rd_q      <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            bmag_q    <= '0;
            result_q  <= '0;
            rd_out_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_sel_q <= rem_sel_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            rd_q      <= rd_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            bmag_q    <= bmag_d;
            result_q  <= result_d;
            rd_out_q  <= rd_out_d;
        end
    end

    assign o_ready  = (state_q == S_IDLE);
    assign o_valid  = (state_q == S_DONE);
    assign o_result = result_q;
    assign o_rd     = rd_out_q;

endmodule
